irq_arbiter_ctrl: RTL and testbench
===================================

// Module: irq_arbiter_ctrl
// PURPOSE
//  Interrupt controller between the external irq_i lines and the RISC-V core trap logic.
//  Registers and masks the 32 interrupt inputs, picks one winner by fixed priority and presents it to the core.
//  Computes the trap vector address (direct or vectored mtvec) and runs the request/take/ack handshake.
//  Drives irq_ack_o / irq_id_o back to the environment.
// PARAMETERS
//  IRQ_W          32            number of interrupt lines (fixed 32 for RV32 mie/mip)
//  ID_W           5             width of interrupt index
//  IRQ_VALID_MASK 32'hFFFF_0888 implemented lines: MSI(3), MTI(7), MEI(11), fast 16..31; others never pend
//  VEC_ALIGN      8             log2 mtvec base alignment in vectored mode (256 B)
// PORTS
//  clk             in   1   core clock
//  rst_n           in   1   asynchronous active-low reset
//  irq_i           in   32  interrupt inputs, level, synchronous to clk
//  mie_i           in   32  per-line enable (CSR mie)
//  mstatus_mie_i   in   1   global enable (mstatus.MIE)
//  mtvec_mode_i    in   1   0 = direct, 1 = vectored
//  mtvec_base_i    in   32  mtvec base address
//  core_take_i     in   1   core accepts the presented interrupt (trap entry), 1-cycle pulse
//  irq_req_o       out  1   interrupt request to core
//  irq_req_id_o    out  5   index of requested interrupt, stable while irq_req_o=1
//  irq_vec_addr_o  out  32  trap target PC for irq_req_id_o
//  irq_ack_o       out  1   1-cycle acknowledge to environment
//  irq_id_o        out  5   index of acknowledged interrupt, valid with irq_ack_o
//  irq_pending_o   out  32  pending vector (mip view), masked by IRQ_VALID_MASK
// BEHAVIOUR
//  Reset: state IDLE; pend_q=0; all outputs 0. Reset asserted mid-REQ/ACK drops irq_req_o/irq_ack_o immediately.
//  Pending: pend_q updates every clk from irq_i & IRQ_VALID_MASK (see CONFIGURATION); irq_pending_o = pend_q.
//  Eligible = pend_q & mie_i. Priority: highest set index wins (31 > ... > 16 > 11 > 7 > 3).
//  FSM IDLE: if mstatus_mie_i && |eligible -> latch winner into id_q, go REQ. core_take_i ignored in IDLE.
//  FSM REQ: irq_req_o=1, irq_req_id_o=id_q; no re-arbitration (a higher-priority arrival waits).
//    core_take_i=1 -> ACK (take wins over any same-cycle withdrawal).
//    else if !mstatus_mie_i or !eligible[id_q] -> withdraw: irq_req_o=0, back to IDLE.
//  FSM ACK: one cycle; irq_ack_o=1, irq_id_o=id_q, irq_req_o=0; go IDLE.
//    Core clears mstatus.MIE on trap entry, which blocks the next request.
//  Latency: irq_i rising at edge N -> pend_q at N+1 -> irq_req_o high after edge N+2.
//    core_take_i at edge M -> irq_ack_o high for cycle after M.
//  Vector: direct -> {mtvec_base_i[31:2],2'b00}; vectored -> {mtvec_base_i[31:VEC_ALIGN], {(VEC_ALIGN-7){1'b0}}, id_q, 2'b00}.
//    irq_vec_addr_o is registered with id_q and constant while in REQ.
//  irq_req_id_o, irq_vec_addr_o = 0 when not in REQ; irq_id_o = 0 when irq_ack_o=0.
// CONFIGURATION
//  IRQ_LATCH_EN defined: pend_q bit sets on rising edge of irq_i (sticky).
//    Cleared only in ACK for id_q; set-edge in the same cycle as ACK clear -> set wins.
//    Withdrawal then occurs only via mstatus_mie_i / mie_i.
//  IRQ_LATCH_EN undefined: level mode; pend_q = registered irq_i & IRQ_VALID_MASK.
//    The source dropping during REQ withdraws the request.
// TESTING
//  1. mstatus_mie_i=1, mie_i=1<<11, irq_i[11] 0->1 -> irq_req_o=1 two clks later with id=11;
//     take -> irq_ack_o 1-cycle pulse, irq_id_o=11.
//  2. irq_i[7] and irq_i[20] set together, both enabled -> id=20.
//     After ack, with MIE re-set and irq_i[20] low -> id=7 next.
//  3. mtvec_base_i=32'h0000_1000: mode 1, id=11 -> irq_vec_addr_o=32'h0000_102C; mode 0 -> 32'h0000_1000.
//  4. Level mode: in REQ for id=3, irq_i[3] drops without take -> irq_req_o=0 next cycle, no ack.
//     Same with take in the withdrawal cycle -> ack id=3.
//  5. IRQ_LATCH_EN: 1-cycle pulse on irq_i[16] while mstatus_mie_i=0 -> irq_pending_o[16]=1 held;
//     set MIE -> req id=16; ack clears bit 16.
//  6. rst_n low during REQ -> irq_req_o, irq_pending_o=0 asynchronously; irq_i[5] set never pends (not in mask).

Source files
------------

// File: rtl/irq_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_arbiter_ctrl
// Brief    : Registers/masks 32 interrupt lines, picks a fixed-priority
//            winner, computes the mtvec trap vector and runs the core
//            request/take/ack handshake. Optional macro IRQ_LATCH_EN
//            selects sticky edge-latched pending bits instead of level mode.
// Revision : 1.0 - initial release
// ============================================================================
module irq_arbiter_ctrl #(
    parameter int                IRQ_W          = 32,
    parameter int                ID_W           = 5,
    parameter logic [IRQ_W-1:0]  IRQ_VALID_MASK = 32'hFFFF_0888,
    parameter int                VEC_ALIGN      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IRQ_W-1:0]  irq_i,
    input  logic [IRQ_W-1:0]  mie_i,
    input  logic              mstatus_mie_i,
    input  logic              mtvec_mode_i,
    input  logic [31:0]       mtvec_base_i,
    input  logic              core_take_i,
    output logic              irq_req_o,
    output logic [ID_W-1:0]   irq_req_id_o,
    output logic [31:0]       irq_vec_addr_o,
    output logic              irq_ack_o,
    output logic [ID_W-1:0]   irq_id_o,
    output logic [IRQ_W-1:0]  irq_pending_o
);

    localparam logic [31:0] VEC_BASE_MASK = ~((32'd1 << VEC_ALIGN) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IRQ_W-1:0]   pend_q,  pend_d;
    logic [ID_W-1:0]    id_q,    id_d;
    logic [31:0]        vec_q,   vec_d;
    logic [IRQ_W-1:0]   eligible;
    logic [ID_W-1:0]    winner;
    logic [31:0]        winner_vec;

    assign eligible = pend_q & mie_i;

    // Ascending scan so the highest set index is the last one written.
    always_comb begin
        winner = '0;
        for (int i = 0; i < IRQ_W; i++) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        if (mtvec_mode_i) begin
            winner_vec = (mtvec_base_i & VEC_BASE_MASK)
                       | {{(32-ID_W-2){1'b0}}, winner, 2'b00};
        end else begin
            winner_vec = {mtvec_base_i[31:2], 2'b00};
        end
    end

`ifdef IRQ_LATCH_EN
    logic [IRQ_W-1:0] irq_prev_q, irq_prev_d;
    logic [IRQ_W-1:0] ack_clr;

    // A new rising edge in the ACK cycle must survive the clear.
    always_comb begin
        irq_prev_d = irq_i;
        ack_clr    = '0;
        if (state_q == ST_ACK) begin
            ack_clr = {{(IRQ_W-1){1'b0}}, 1'b1} << id_q;
        end
        pend_d = (pend_q & ~ack_clr) | (irq_i & ~irq_prev_q & IRQ_VALID_MASK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev_q <= '0;
        end else begin
            irq_prev_q <= irq_prev_d;
        end
    end
`else
    always_comb begin
        pend_d = irq_i & IRQ_VALID_MASK;
    end
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        vec_d   = vec_q;
        case (state_q)
            ST_IDLE: begin
                if (mstatus_mie_i && (|eligible)) begin
                    state_d = ST_REQ;
                    id_d    = winner;
                    vec_d   = winner_vec;
                end
            end
            ST_REQ: begin
                if (core_take_i) begin
                    state_d = ST_ACK;
                end else if (!mstatus_mie_i || !eligible[id_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            id_q    <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            id_q    <= id_d;
            vec_q   <= vec_d;
        end
    end

    assign irq_req_o      = (state_q == ST_REQ);
    assign irq_req_id_o   = irq_req_o ? id_q  : '0;
    assign irq_vec_addr_o = irq_req_o ? vec_q : '0;
    assign irq_ack_o      = (state_q == ST_ACK);
    assign irq_id_o       = irq_ack_o ? id_q  : '0;
    assign irq_pending_o  = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_arbiter_ctrl
// Brief    : Self-checking bench: vector table, directed handshake corner
//            sequences and randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_arbiter_ctrl;

    localparam logic [31:0] C_MASK = 32'hFFFF_0888;

    logic        clk;
    logic        rst_n;
    logic [31:0] irq;
    logic [31:0] mie;
    logic        mstatus;
    logic        mode;
    logic [31:0] base;
    logic        take;
    logic        req_o;
    logic [4:0]  req_id_o;
    logic [31:0] vec_o;
    logic        ack_o;
    logic [4:0]  id_o;
    logic [31:0] pend_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: phase 0 = idle, 1 = requesting, 2 = acknowledging
    logic [31:0] m_pend;
    logic [31:0] m_prev;
    int          m_phase;
    int          m_id;
    logic [31:0] m_vec;

    typedef struct {
        logic [31:0] irq;
        logic        mode;
        logic [31:0] base;
        logic [4:0]  exp_id;
        logic [31:0] exp_vec;
    } vec_t;

    vec_t tbl [6];

    irq_arbiter_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_i          (irq),
        .mie_i          (mie),
        .mstatus_mie_i  (mstatus),
        .mtvec_mode_i   (mode),
        .mtvec_base_i   (base),
        .core_take_i    (take),
        .irq_req_o      (req_o),
        .irq_req_id_o   (req_id_o),
        .irq_vec_addr_o (vec_o),
        .irq_ack_o      (ack_o),
        .irq_id_o       (id_o),
        .irq_pending_o  (pend_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int highest(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] vec_of(input logic md, input logic [31:0] b, input int id);
        if (md) return (b - (b % 32'd256)) + 32'(id * 4);
        return b - (b % 32'd4);
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_prev  = '0;
        m_phase = 0;
        m_id    = 0;
        m_vec   = '0;
    endtask

    task automatic model_tick();
        logic [31:0] elig;
        logic [31:0] clr;
        int          nphase;
        elig   = m_pend & mie;
        nphase = m_phase;
        clr    = (m_phase == 2) ? (32'd1 << m_id) : 32'd0;
        if (m_phase == 0) begin
            if (mstatus && elig != 0) begin
                nphase = 1;
                m_id   = highest(elig);
                m_vec  = vec_of(mode, base, m_id);
            end
        end else if (m_phase == 1) begin
            if (take) nphase = 2;
            else if (!mstatus || !elig[m_id]) nphase = 0;
        end else begin
            nphase = 0;
        end
`ifdef IRQ_LATCH_EN
        m_pend = (m_pend & ~clr) | (irq & ~m_prev & C_MASK);
`else
        m_pend = irq & C_MASK;
`endif
        m_prev  = irq;
        m_phase = nphase;
    endtask

    task automatic step();
        if (rst_n) model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        check("rnd_req",    32'(req_o),    32'(m_phase == 1));
        check("rnd_req_id", 32'(req_id_o), (m_phase == 1) ? 32'(m_id) : 32'd0);
        check("rnd_vec",    vec_o,         (m_phase == 1) ? m_vec : 32'd0);
        check("rnd_ack",    32'(ack_o),    32'(m_phase == 2));
        check("rnd_id",     32'(id_o),     (m_phase == 2) ? 32'(m_id) : 32'd0);
        check("rnd_pend",   pend_o,        m_pend);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        irq     = '0;
        mie     = '0;
        mstatus = 1'b0;
        mode    = 1'b0;
        base    = '0;
        take    = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{32'h0000_0800, 1'b1, 32'h0000_1000, 5'd11, 32'h0000_102C};
        tbl[1] = '{32'h0000_0800, 1'b0, 32'h0000_1000, 5'd11, 32'h0000_1000};
        tbl[2] = '{32'h0010_0080, 1'b1, 32'h0000_1000, 5'd20, 32'h0000_1050};
        tbl[3] = '{32'h8000_0008, 1'b1, 32'hABCD_EF77, 5'd31, 32'hABCD_EF7C};
        tbl[4] = '{32'h0000_0008, 1'b0, 32'hABCD_EF77, 5'd3,  32'hABCD_EF74};
        tbl[5] = '{32'h0001_0020, 1'b1, 32'h8000_00FF, 5'd16, 32'h8000_0040};

        do_reset();
        check("reset_req",  32'(req_o), 32'd0);
        check("reset_ack",  32'(ack_o), 32'd0);
        check("reset_pend", pend_o,     32'd0);
        check("reset_vec",  vec_o,      32'd0);

        // Basic latency and handshake on MEI
        mstatus = 1'b1;
        mie     = 32'h0000_0800;
        irq     = 32'h0000_0800;
        step();
        check("lat_req_early", 32'(req_o), 32'd0);
        check("lat_pend",      pend_o,     32'h0000_0800);
        step();
        check("lat_req",    32'(req_o),    32'd1);
        check("lat_req_id", 32'(req_id_o), 32'd11);
        take    = 1'b1;
        mstatus = 1'b0;
        step();
        take = 1'b0;
        check("lat_ack",     32'(ack_o), 32'd1);
        check("lat_ack_id",  32'(id_o),  32'd11);
        check("lat_ack_req", 32'(req_o), 32'd0);
        step();
        check("lat_ack_pulse", 32'(ack_o), 32'd0);
        check("lat_id_clear",  32'(id_o),  32'd0);

        // Vector/priority table
        foreach (tbl[k]) begin
            do_reset();
            irq     = tbl[k].irq;
            mie     = 32'hFFFF_FFFF;
            mstatus = 1'b1;
            mode    = tbl[k].mode;
            base    = tbl[k].base;
            step();
            step();
            check("tbl_req",    32'(req_o),    32'd1);
            check("tbl_req_id", 32'(req_id_o), 32'(tbl[k].exp_id));
            check("tbl_vec",    vec_o,         tbl[k].exp_vec);
            take = 1'b1;
            irq  = '0;
            step();
            take = 1'b0;
            check("tbl_ack",    32'(ack_o), 32'd1);
            check("tbl_ack_id", 32'(id_o),  32'(tbl[k].exp_id));
            check("tbl_vec_off", vec_o,     32'd0);
        end

        // Lower priority served after the higher one leaves
        do_reset();
        irq     = 32'h0010_0080;
        mie     = 32'hFFFF_FFFF;
        mstatus = 1'b1;
        step();
        step();
        check("prio_first", 32'(req_id_o), 32'd20);
        take = 1'b1;
        irq  = 32'h0000_0080;
        step();
        take = 1'b0;
        check("prio_ack20", 32'(id_o), 32'd20);
        step();
        check("prio_idle", 32'(req_o), 32'd0);
        step();
        check("prio_second", 32'(req_id_o), 32'd7);

`ifndef IRQ_LATCH_EN
        // Source drops during REQ: withdrawal, then take in withdrawal cycle
        do_reset();
        irq     = 32'h0000_0008;
        mie     = 32'hFFFF_FFFF;
        mstatus = 1'b1;
        step();
        step();
        check("wd_req", 32'(req_id_o), 32'd3);
        irq = '0;
        step();
        check("wd_hold", 32'(req_o), 32'd1);
        step();
        check("wd_drop",  32'(req_o), 32'd0);
        check("wd_noack", 32'(ack_o), 32'd0);
        step();
        check("wd_noack2", 32'(ack_o), 32'd0);
        irq = 32'h0000_0008;
        step();
        step();
        check("wt_req", 32'(req_o), 32'd1);
        irq = '0;
        step();
        take = 1'b1;
        step();
        take = 1'b0;
        check("wt_ack",    32'(ack_o), 32'd1);
        check("wt_ack_id", 32'(id_o),  32'd3);
`else
        // Sticky pulse captured while globally disabled
        do_reset();
        mie = 32'hFFFF_FFFF;
        irq = 32'h0001_0000;
        step();
        irq = '0;
        step();
        step();
        check("latch_held", pend_o,     32'h0001_0000);
        check("latch_noreq", 32'(req_o), 32'd0);
        mstatus = 1'b1;
        step();
        check("latch_req", 32'(req_id_o), 32'd16);
        take = 1'b1;
        step();
        take    = 1'b0;
        mstatus = 1'b0;
        check("latch_ack", 32'(id_o), 32'd16);
        step();
        check("latch_clr", pend_o, 32'd0);
`endif

        // Asynchronous reset during REQ; unimplemented line never pends
        do_reset();
        irq     = 32'h0000_0800;
        mie     = 32'hFFFF_FFFF;
        mstatus = 1'b1;
        step();
        step();
        check("ar_req", 32'(req_o), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("ar_req_drop", 32'(req_o), 32'd0);
        check("ar_pend",     pend_o,     32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        irq   = 32'h0000_0020;
        step();
        step();
        step();
        check("mask_pend", pend_o,     32'd0);
        check("mask_req",  32'(req_o), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) irq = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 7) == 0) mie = $urandom | $urandom;
            mstatus = ($urandom_range(0, 3) != 0);
            take    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) base = $urandom;
            step();
            check_all();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
